// File: rtl/ripple_adder_4bit.sv
// ripple_adder_4bit: registered 4-bit ripple-carry adder built from four full-adder cells.
// Define RIPPLE_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module ripple_adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       in_valid,
  output logic [3:0] sum,
  output logic       cout,
  output logic       out_valid
`ifdef RIPPLE_ADDER_OVF_EN
  ,
  output logic       ovf
`endif
);
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    return {x & y | x & ci | y & ci, x ^ y ^ ci};
  endfunction
  logic [3:0] s;
  logic       c1, c2, c3, c4;
  logic [3:0] sum_d, sum_q;
  logic       cout_d, cout_q, out_valid_d, out_valid_q;
  // Each cell consumes the carry of the one below it, so the carry ripples LSB to MSB.
  always_comb begin
    {c1, s[0]} = fa(a[0], b[0], cin);
    {c2, s[1]} = fa(a[1], b[1], c1);
    {c3, s[2]} = fa(a[2], b[2], c2);
    {c4, s[3]} = fa(a[3], b[3], c3);
    sum_d       = in_valid ? s : sum_q;
    cout_d      = in_valid ? c4 : cout_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef RIPPLE_ADDER_OVF_EN
  logic ovf_d, ovf_q;
  always_comb ovf_d = in_valid ? c3 ^ c4 : ovf_q;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_ripple_adder_4bit.sv
// tb_ripple_adder_4bit: directed and exhaustive scoreboard bench for ripple_adder_4bit.
module tb_ripple_adder_4bit;
  logic       clk = 1'b0;
  logic       rst, cin, in_valid, cout, out_valid;
  logic [3:0] a, b, sum;
  logic       ovf_obs;
  logic [5:0] sb[$];
  logic [5:0] held;
  int         checks = 0;
  int         errors = 0;
`ifdef RIPPLE_ADDER_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif
  always #5 clk = ~clk;
  ripple_adder_4bit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .cout(cout), .out_valid(out_valid)
`ifdef RIPPLE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  // {ovf, cout, sum}; ovf only carries meaning when the overflow output is built.
  function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] r;
    logic       o;
    r = {1'b0, x} + {1'b0, y} + {4'b0, c};
    o = (x[3] == y[3]) && (r[3] != x[3]);
`ifdef RIPPLE_ADDER_OVF_EN
    return {o, r};
`else
    return {1'b0 & o, r};
`endif
  endfunction
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                      input logic tv, input logic tr);
    logic [5:0] e;
    a = ta; b = tb_; cin = tc; in_valid = tv; rst = tr;
    if (tv && !tr) sb.push_back(model(ta, tb_, tc));
    @(posedge clk);
    #1;
    if (tr) begin
      sb.delete();
      held = '0;
      chk("rst_valid", {5'b0, out_valid}, 6'd0);
      chk("rst_result", {ovf_obs, cout, sum}, 6'd0);
    end else if (tv) begin
      chk("valid", {5'b0, out_valid}, 6'd1);
      if (sb.size() == 0) begin
        chk("sb_underflow", 6'd1, {5'b0, out_valid ^ 1'b1});
      end else begin
        e = sb.pop_front();
        chk("result", {1'b0, cout, sum}, {1'b0, e[4:0]});
        chk("ovf", {5'b0, ovf_obs}, {5'b0, e[5]});
        held = e;
      end
    end else begin
      chk("idle_valid", {5'b0, out_valid}, 6'd0);
      chk("hold", {ovf_obs, cout, sum}, held);
    end
  endtask
  initial begin
    held = '0;
    step(4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1);
    step(4'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1);
    step(4'd5, 4'd9, 1'b0, 1'b1, 1'b0);
    chk("d_5_9", {1'b0, cout, sum}, 6'h0E);
    step(4'd7, 4'd7, 1'b1, 1'b0, 1'b0);
    chk("d_hold", {out_valid, cout, sum}, 6'h0E);
    step(4'd11, 4'd4, 1'b0, 1'b1, 1'b0);
    chk("d_11_4", {1'b0, cout, sum}, 6'h0F);
    step(4'd15, 4'd9, 1'b0, 1'b1, 1'b0);
    chk("d_15_9", {1'b0, cout, sum}, 6'h18);
    step(4'd2, 4'd3, 1'b0, 1'b1, 1'b0);
    chk("d_2_3", {1'b0, cout, sum}, 6'h05);
    step(4'd15, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("d_15_0_1", {1'b0, cout, sum}, 6'h10);
    step(4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
    chk("d_15_15_1", {1'b0, cout, sum}, 6'h1F);
    step(4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("d_0_0_0", {1'b0, cout, sum}, 6'h00);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      if (i == 300) step(v[3:0], v[7:4], v[8], 1'b1, 1'b1);
      step(v[3:0], v[7:4], v[8], 1'b1, 1'b0);
    end
    step(4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", 6'(sb.size()), 6'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
